// File: rtl/data_mem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
package data_mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [3:0] BASE_MASK_B = 4'b0001;
  localparam logic [3:0] BASE_MASK_H = 4'b0011;
  localparam logic [3:0] BASE_MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Access size in bytes; 0 flags the reserved size encoding.
  function automatic logic [2:0] size_bytes(input logic [2:0] op);
    case (op[1:0])
      OP_B[1:0]: size_bytes = 3'd1;
      OP_H[1:0]: size_bytes = 3'd2;
      OP_W[1:0]: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] base_mask(input logic [2:0] op);
    case (op[1:0])
      OP_B[1:0]: base_mask = BASE_MASK_B;
      OP_H[1:0]: base_mask = BASE_MASK_H;
      OP_W[1:0]: base_mask = BASE_MASK_W;
      default:   base_mask = 4'b0000;
    endcase
  endfunction

  // Reserved size, or an unsigned variant used as a store.
  function automatic logic op_illegal(input logic [2:0] op, input logic we);
    op_illegal = (op[1:0] == 2'b11) || (op[2] && we);
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bus between the core's data-memory controller and the responder.
interface data_mem_resp_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
module data_mem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read data holds its value while the port is idle or writing.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Memory-side load/store responder: byte-lane placement into word RAM, unextended load return.
// Build option DATA_MEM_RESP_MISALIGN_SPLIT_EN splits word-crossing accesses; otherwise misaligned accesses error.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_resp_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
  localparam int unsigned LANES = 7;
`else
  localparam int unsigned LANES = 4;
`endif
  localparam int unsigned LANE_BITS = 8 * LANES;

  state_e                state_q, state_d;
  logic                  we_q, err_q;
  logic [2:0]            op_q;
  logic [1:0]            off_q;
  logic [IDX_W-1:0]      widx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept_c;
  logic [1:0]            req_off_c;
  logic [2:0]            req_size_c;
  logic                  req_err_c;
  logic                  req_split_c;

  logic                  ram_en_c, ram_we_c;
  logic [3:0]            ram_be_c;
  logic [IDX_W-1:0]      ram_addr_c;
  logic [31:0]           ram_wdata_c, ram_rdata;

  logic [LANES-1:0]      mask_c;
  logic [LANE_BITS-1:0]  lane_data_c;
  logic [31:0]           load_shift_c, load_c;
  logic [3:0]            load_bm_c;

`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
  logic                  split_q;
  logic [31:0]           word0_q;
  logic [63:0]           load_pair_c;
`endif

  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign accept_c      = bus.req_valid && bus.req_ready;

  // Request decode at the accept edge.
  assign req_off_c  = bus.req_addr[1:0];
  assign req_size_c = size_bytes(bus.req_op);
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
  assign req_err_c   = op_illegal(bus.req_op, bus.req_we);
  assign req_split_c = !req_err_c && (({1'b0, req_off_c} + req_size_c) > 3'd4);
`else
  assign req_err_c   = op_illegal(bus.req_op, bus.req_we) ||
                       ((req_off_c & 2'(req_size_c - 3'd1)) != 2'b00);
  assign req_split_c = 1'b0;
`endif

  // Lane placement across the addressed word and, when split, the next one.
  assign mask_c      = LANES'(base_mask(op_q)) << off_q;
  assign lane_data_c = LANE_BITS'(wdata_q) << {off_q, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      word0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        we_q    <= bus.req_we;
        err_q   <= req_err_c;
        op_q    <= bus.req_op;
        off_q   <= req_off_c;
        widx_q  <= bus.req_addr[IDX_W+1:2];
        wdata_q <= bus.req_wdata;
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
        split_q <= req_split_c;
`endif
      end
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
      // First word of a split load is on the RAM output during ACC1.
      if (state_q == ACC1) word0_q <= ram_rdata;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_be_c    = 4'b0000;
    ram_addr_c  = widx_q;
    ram_wdata_c = lane_data_c[31:0];
    case (state_q)
      IDLE: if (accept_c) state_d = ACC0;
      ACC0: begin
        ram_en_c = !err_q;
        ram_we_c = we_q;
        ram_be_c = mask_c[3:0];
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
        state_d  = split_q ? ACC1 : RESP;
`else
        state_d  = RESP;
`endif
      end
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
      ACC1: begin
        ram_en_c    = 1'b1;
        ram_we_c    = we_q;
        ram_be_c    = {1'b0, mask_c[6:4]};
        ram_addr_c  = widx_q + IDX_W'(1);
        ram_wdata_c = {8'h00, lane_data_c[55:32]};
        state_d     = RESP;
      end
`endif
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  data_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (ram_en_c),
    .we_i   (ram_we_c),
    .be_i   (ram_be_c),
    .addr_i (ram_addr_c),
    .wdata_i(ram_wdata_c),
    .rdata_o(ram_rdata)
  );

  // Load return: right-justify, then clear bytes above the access size.
`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
  assign load_pair_c  = {ram_rdata, (split_q ? word0_q : ram_rdata)};
  assign load_shift_c = 32'(load_pair_c >> {off_q, 3'b000});
`else
  assign load_shift_c = ram_rdata >> {off_q, 3'b000};
`endif

  always_comb begin
    load_bm_c = base_mask(op_q);
    load_c    = '0;
    for (int b = 0; b < 4; b++) begin
      load_c[8*b +: 8] = load_shift_c[8*b +: 8] & {8{load_bm_c[b]}};
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? DATA_WIDTH'(load_c) : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed, table-driven bench for data_mem_resp; expectations follow the build option
// DATA_MEM_RESP_MISALIGN_SPLIT_EN.
module tb_data_mem_resp;
  import data_mem_pkg::*;

`ifdef DATA_MEM_RESP_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int TMO = 20;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vq[$];

  data_mem_resp_if bus ();

  data_mem_resp dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat);
    vq.push_back('{we, op, addr, wdata, exp_rdata, exp_err, exp_lat});
  endtask

  // Present a request and return just after its accept edge.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input string name);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TMO) check({name, " accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Edges from the accept edge to the edge that samples rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_xact(input vec_t v, input string name);
    int lat;
    bus.rsp_ready = 1'b1;
    issue(v.we, v.op, v.addr, v.wdata, name);
    wait_rsp(lat);
    check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({name, " err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    @(posedge clk); #1;
    check({name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] w0;
    vec_t        v;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = OP_B;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset req_ready low", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset req_ready high", 32'(bus.req_ready), 32'd1);

    //  we    op     addr          wdata         exp_rdata                         err        lat
    add(1'b1, OP_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0,                           1'b0,      2);
    add(1'b0, OP_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF,                   1'b0,      2);
    add(1'b1, OP_W,  32'h0000_0010, 32'h1122_3344, 32'h0,                           1'b0,      2);
    add(1'b1, OP_B,  32'h0000_0013, 32'h0000_00AA, 32'h0,                           1'b0,      2);
    add(1'b0, OP_BU, 32'h0000_0013, 32'h0,         32'h0000_00AA,                   1'b0,      2);
    add(1'b0, OP_W,  32'h0000_0010, 32'h0,         32'hAA22_3344,                   1'b0,      2);
    add(1'b0, OP_B,  32'h0000_0012, 32'h0,         32'h0000_0022,                   1'b0,      2);
    add(1'b0, OP_H,  32'h0000_0012, 32'h0,         32'h0000_AA22,                   1'b0,      2);
    add(1'b0, OP_HU, 32'h0000_0010, 32'h0,         32'h0000_3344,                   1'b0,      2);
    add(1'b0, OP_W,  32'h0000_1010, 32'h0,         32'hAA22_3344,                   1'b0,      2);
    add(1'b1, OP_W,  32'h0000_0000, 32'h5566_7788, 32'h0,                           1'b0,      2);
    add(1'b0, OP_H,  32'h0000_0001, 32'h0,         SPLIT_EN ? 32'h0000_6677 : 32'h0, !SPLIT_EN, 2);
    add(1'b1, OP_H,  32'h0000_0001, 32'h0000_FFFF, 32'h0,                           !SPLIT_EN, 2);
    add(1'b0, OP_W,  32'h0000_0000, 32'h0,         SPLIT_EN ? 32'h55FF_FF88 : 32'h5566_7788, 1'b0, 2);
    add(1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h0,                           1'b1,      2);
    add(1'b1, OP_BU, 32'h0000_0010, 32'h0000_00FF, 32'h0,                           1'b1,      2);
    add(1'b0, OP_W,  32'h0000_0010, 32'h0,         32'hAA22_3344,                   1'b0,      2);
    add(1'b1, OP_H,  32'h0000_0012, 32'h0000_BEEF, 32'h0,                           1'b0,      2);
    add(1'b0, OP_W,  32'h0000_0010, 32'h0,         32'hBEEF_3344,                   1'b0,      2);
    add(1'b1, OP_W,  32'h0000_000C, 32'h0,         32'h0,                           1'b0,      2);
    add(1'b1, OP_W,  32'h0000_0010, 32'h0,         32'h0,                           1'b0,      2);
    add(1'b1, OP_W,  32'h0000_000E, 32'hCAFE_BABE, 32'h0,                 !SPLIT_EN, SPLIT_EN ? 3 : 2);
    add(1'b0, OP_W,  32'h0000_000E, 32'h0, SPLIT_EN ? 32'hCAFE_BABE : 32'h0, !SPLIT_EN, SPLIT_EN ? 3 : 2);
    add(1'b0, OP_W,  32'h0000_000C, 32'h0, SPLIT_EN ? 32'hBABE_0000 : 32'h0, 1'b0,      2);
    add(1'b0, OP_W,  32'h0000_0010, 32'h0, SPLIT_EN ? 32'h0000_CAFE : 32'h0, 1'b0,      2);
    add(1'b0, OP_HU, 32'h0000_000F, 32'h0, SPLIT_EN ? 32'h0000_FEBA : 32'h0, !SPLIT_EN, SPLIT_EN ? 3 : 2);
    add(1'b1, OP_W,  32'h0000_0FFE, 32'h1234_5678, 32'h0,                 !SPLIT_EN, SPLIT_EN ? 3 : 2);
    add(1'b0, OP_W,  32'h0000_0000, 32'h0, SPLIT_EN ? 32'h55FF_1234 : 32'h5566_7788, 1'b0, 2);
    add(1'b0, OP_W,  32'h0000_0FFE, 32'h0, SPLIT_EN ? 32'h1234_5678 : 32'h0, !SPLIT_EN, SPLIT_EN ? 3 : 2);

    for (int i = 0; i < vq.size(); i++) begin
      run_xact(vq[i], $sformatf("vec%0d", i));
    end

    // Response held off: outputs stay stable and no new request is taken.
    w0 = SPLIT_EN ? 32'h55FF_1234 : 32'h5566_7788;
    bus.rsp_ready = 1'b0;
    issue(1'b0, OP_W, 32'h0000_0000, 32'h0, "hold");
    wait_rsp(lat);
    check("hold latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("hold%0d rdata", c), bus.rsp_rdata, w0);
      check($sformatf("hold%0d req_ready", c), 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold release req_ready", 32'(bus.req_ready), 32'd1);

    // Reset during an in-flight store aborts it.
    if (SPLIT_EN) begin
      v = '{1'b1, OP_W, 32'h0000_001C, 32'h0, 32'h0, 1'b0, 2};
      run_xact(v, "clr1c");
      v = '{1'b1, OP_W, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 2};
      run_xact(v, "clr20");
      issue(1'b1, OP_W, 32'h0000_001E, 32'h0102_0304, "rstsplit");
      @(posedge clk); #1;
      check("rst in ACC1 rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end else begin
      issue(1'b1, OP_W, 32'h0000_001C, 32'h0102_0304, "rststore");
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("midrst rsp_err", 32'(bus.rsp_err), 32'd0);
    check("midrst req_ready low", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst req_ready high", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst no late rsp", 32'(bus.rsp_valid), 32'd0);
    if (SPLIT_EN) begin
      v = '{1'b0, OP_W, 32'h0000_001C, 32'h0, 32'h0304_0000, 1'b0, 2};
      run_xact(v, "midrst word0");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Memory-side responder for the core's load/store port; the opposite end of the core-side data-memory controller.
- Accepts one request at a time: address, funct3 op, write data, write flag.
- Performs byte-lane placement into a word-organised synchronous RAM with per-byte write enables.
- Returns load data right-justified but not extended, so the core's controller applies sign or zero extension.

Parameters:
DATA_WIDTH, 32, data word width; only 32 is supported.
ADDR_WIDTH, 32, byte-address width.
DEPTH_WORDS, 1024, RAM depth in words; must be a power of 2.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  high only in IDLE with rst_n=1
req_we  in  1  1=store, 0=load
req_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  DATA_WIDTH  load data, right-justified, unextended; 0 for stores and errors
rsp_err  out  1  illegal op (or misaligned access, see Optional Feature)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- Reset mid-operation aborts the transfer. A split store may leave word0 written and word1 unwritten; this is accepted behaviour.
- Handshake:
  - A request is accepted when req_valid && req_ready. All request fields are registered at that edge.
  - Once asserted, rsp_valid stays high and rsp_rdata/rsp_err stay stable until rsp_ready. The state returns to IDLE at the same edge.
  - A new request can be accepted in the cycle after the response handshake.
- States: IDLE -> ACC0 -> (ACC1 if split) -> RESP -> IDLE.
  - Latency from the accept edge to rsp_valid: aligned = 2 cycles; split = 3 cycles.
  - With rsp_ready held high, the response is consumed in the first RESP cycle.
- Size: op[1:0]: 00=1 byte, 01=2 bytes, 10=4 bytes.
- Illegal ops:
  - op[1:0]=11 is illegal.
  - op[2]=1 with req_we=1 is illegal.
  - An illegal op passes through ACC0 with no RAM enable, then RESP with rsp_err=1 and rsp_rdata=0. Latency is 2.
- Lanes:
  - off = addr[1:0]; widx = addr[ADDR_WIDTH-1:2] mod DEPTH_WORDS.
  - Store mask = (0001/0011/1111) << off, 7 bits wide. Bits [3:0] apply to widx and bits [6:4] to widx+1.
  - Store data = wdata << 8*off, 56 bits wide. The low word goes to widx; the high 24 bits go to widx+1, lanes 0-2.
  - A split occurs iff off + size > 4.
  - Load result = ({word1,word0} >> 8*off), low 32 bits, with bytes above the size zeroed.
- RAM timing: read is synchronous with 1-cycle latency. A write commits at the end of the ACC cycle that drives it.
- Wrap: widx = DEPTH_WORDS-1 with a split makes word1 index 0.
- Stores return rsp_valid with rsp_rdata=0 and rsp_err=0 (write acknowledge).

Optional Feature:
- Macro: DATA_MEM_RESP_MISALIGN_SPLIT_EN.
- Defined: a misaligned access crossing a word boundary is split across two words as above.
- Undefined: any access with off not a multiple of size returns rsp_err=1, rsp_rdata=0, latency 2, and performs no RAM write. This applies even when the access stays inside one word (e.g. lh at off=1). ACC1 is not built.

Decomposition:
- Package data_mem_pkg:
  - funct3 op constants (OP_B=000, OP_H=001, OP_W=010, OP_BU=100, OP_HU=101).
  - Size decode function.
  - State enum (IDLE, ACC0, ACC1, RESP).
  - Base-mask constants.
- Sub-module data_mem_ram: single-port RAM, DEPTH_WORDS x 32, with 4 byte write enables and a synchronous registered read.

Test Plan:
- Store sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> store ack after 2 cycles with err=0; load rdata=0xDEADBEEF after 2 cycles.
- Store sb addr 0x13 data 0x000000AA over word 0x11223344, then lbu 0x13 and lw 0x10 -> lbu returns 0x000000AA; lw returns 0xAA223344.
- With EN defined: sw addr 0x0E data 0xCAFEBABE, then lw 0x0E -> both split (3 cycles); load returns 0xCAFEBABE; word 0x0C upper half = 0xBABE, word 0x10 lower half = 0xCAFE.
- With EN undefined: lh addr 0x01 -> rsp_err=1, rsp_rdata=0, no memory change.
- Illegal op=011 load, op=100 store -> rsp_err=1, latency 2, no write. Also: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
- Reset pulsed in ACC1 of a split store -> next cycle state IDLE, rsp_valid=0, req_ready=1 once rst_n is high.
